conv_window_gen: RTL
====================

// Module: conv_window_gen
// PURPOSE
//  Producer side of the 5x5 multiply-accumulate window datapath: turns a
//  row-major pixel stream (one 16-bit Q8.8 pixel per beat) into flattened
//  KxK sliding windows (stride 1, no padding).
//  Sits between the feature-map source and the MAC: each output window is
//  packed exactly as the MAC's matrix operand expects.
//  Frame size is fixed by parameters.
// PARAMETERS
//  DATA_SIZE  16  pixel width, signed Q8.8
//  K          5   window edge length (window = K*K pixels)
//  IMG_W      32  pixels per input row (> K)
//  IMG_H      32  rows per input frame (>= K)
// PORTS
//  clk        in   1                    clock, rising edge
//  rst        in   1                    synchronous reset, active high
//  pix_in     in   DATA_SIZE            input pixel, row-major order
//  pix_valid  in   1                    pix_in valid
//  pix_ready  out  1                    block can accept pix_in this cycle
//  win_out    out  DATA_SIZE*K*K        flattened window
//  win_valid  out  1                    win_out holds a complete window
//  win_ready  in   1                    consumer accepts win_out
//  frame_done out  1                    1-cycle pulse: last window of frame accepted
// BEHAVIOUR
//  - Accept: pixel taken when pix_valid && pix_ready.
//    pix_ready = !win_valid || win_ready, so there is one window register
//    and no skid buffer.
//  - Storage:
//    - K-1 line buffers, each IMG_W deep, read/write addressed by col.
//    - KxK window register: on accept, each row shifts left one column.
//    - New right column = {line_buf[K-2..0][col], pix_in}: oldest row at
//      top, pix_in at bottom-right. The line buffers cascade at col.
//  - Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on accept.
//    - col wraps to 0 and row increments at IMG_W-1.
//    - At row IMG_H-1 / col IMG_W-1 both wrap to 0 and the next frame
//      starts. Line-buffer contents are not cleared; rows <K-1 never emit.
//  - Window emit:
//    - win_valid rises the cycle after accepting a pixel with
//      row >= K-1 && col >= K-1 (latency 1).
//    - win_valid clears on a win_ready handshake unless a new window is
//      loaded in the same cycle.
//    - Accept and win_ready in the same cycle: the new window replaces
//      the old one and win_valid stays 1.
//    - Windows per frame = (IMG_W-K+1)*(IMG_H-K+1), row-major; 784 by default.
//  - Packing: element i = r*K+c (r = window row top to bottom, c = column
//    left to right) sits at win_out[DATA_SIZE*(K*K-i)-1 -: DATA_SIZE].
//    Element 0 (top-left) is in the MSBs.
//  - Stall: win_out and win_valid are stable while win_valid && !win_ready.
//  - frame_done: high the cycle after the handshake of the window whose
//    bottom-right is (IMG_H-1, IMG_W-1).
//  - Reset (also mid-frame):
//    - col, row <= 0; win_valid, frame_done <= 0; win_out <= 0.
//    - pix_ready = 1 the cycle after reset deasserts.
//    - Line buffers are not reset.
//    - The next accepted pixel is (0,0) of a new frame.
//  - Width rules: data passes through unmodified, no arithmetic or
//    saturation. X or Z on pix_in is not scrubbed.
// TESTING
//  1. IMG_W=IMG_H=8, K=5, pix = 16*(row*8+col) (integer, Q8.8), valid
//     always, ready always:
//     - 16 windows.
//     - Window 0 element 0 = 0x0000, element 24 = 0x0240.
//     - Last window element 0 = 0x01B0, element 24 = 0x03F0.
//     - frame_done pulses once.
//  2. Same stream, win_ready low for 7 cycles on window 5:
//     - win_out is held stable and pix_ready = 0 throughout.
//     - No pixel is lost; all 16 windows arrive in order.
//  3. Random pix_valid gaps (~40% idle): the window sequence is identical
//     to case 1.
//  4. Two back-to-back frames: the second frame yields the same 16
//     windows, and frame_done pulses twice.
//  5. rst asserted after 30 pixels (mid row 3), then a full frame is sent:
//     - Same as case 1; no window is emitted before the pixel at (4,4).
//  6. Default params, all pixels 0x0100: 784 windows, each with all 25
//     elements = 0x0100.

Source files
------------

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - KxK sliding-window generator for a row-major pixel stream
// One window register, K-1 line buffers; the window is valid once row and col both reach K-1.
module conv_window_gen #(
   parameter int DATA_SIZE = 16,
   parameter int K         = 5,
   parameter int IMG_W     = 32,
   parameter int IMG_H     = 32
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [DATA_SIZE-1:0]       i_pix_in,
   input  logic                       i_pix_valid,
   output logic                       o_pix_ready,
   output logic [DATA_SIZE*K*K-1:0]   o_win_out,
   output logic                       o_win_valid,
   input  logic                       i_win_ready,
   output logic                       o_frame_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(K - 1);

   logic [CW-1:0]        r_col;
   logic [RW-1:0]        r_row;
   logic [DATA_SIZE-1:0] r_line [K-1][IMG_W];
   logic [DATA_SIZE-1:0] r_win  [K][K];
   logic                 r_win_valid;
   logic                 r_frame_done;
   logic                 r_last_win;

   logic                 w_accept;
   logic                 w_win_hs;
   logic                 w_emit;
   logic                 w_frame_end;
   logic [DATA_SIZE-1:0] w_new_col [K];

   assign o_pix_ready = !r_win_valid || i_win_ready;
   assign w_accept    = i_pix_valid && o_pix_ready;
   assign w_win_hs    = r_win_valid && i_win_ready;
   assign w_emit      = w_accept && (r_row >= ROW_FIRST_WIN) && (r_col >= COL_FIRST_WIN);
   assign w_frame_end = (r_row == ROW_LAST) && (r_col == COL_LAST);

   // Oldest buffered row lands at the top of the new column, the live pixel at the bottom.
   always_comb begin
      for (int r = 0; r < K-1; r++) begin
         w_new_col[r] = r_line[K-2-r][r_col];
      end
      w_new_col[K-1] = i_pix_in;
   end

   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_line[0][r_col] <= i_pix_in;
         for (int j = 1; j < K-1; j++) begin
            r_line[j][r_col] <= r_line[j-1][r_col];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_col        <= '0;
         r_row        <= '0;
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_last_win   <= 1'b0;
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               r_win[r][c] <= '0;
            end
         end
      end else begin
         r_frame_done <= w_win_hs && r_last_win;
         if (w_accept) begin
            for (int r = 0; r < K; r++) begin
               for (int c = 0; c < K-1; c++) begin
                  r_win[r][c] <= r_win[r][c+1];
               end
               r_win[r][K-1] <= w_new_col[r];
            end
            if (r_col == COL_LAST) begin
               r_col <= '0;
               r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         // A freshly loaded window wins over the handshake that retires the old one.
         if (w_emit) begin
            r_win_valid <= 1'b1;
            r_last_win  <= w_frame_end;
         end else if (w_win_hs) begin
            r_win_valid <= 1'b0;
         end
      end
   end

   for (genvar gr = 0; gr < K; gr++) begin : g_row
      for (genvar gc = 0; gc < K; gc++) begin : g_col
         assign o_win_out[DATA_SIZE*(K*K-(gr*K+gc))-1 -: DATA_SIZE] = r_win[gr][gc];
      end
   end

   assign o_win_valid  = r_win_valid;
   assign o_frame_done = r_frame_done;

endmodule
